// File: rtl/hilo_ctrl_if.sv
// Bus between the control unit / Booth multiplier side and the HI/LO controller.
// The slave modport is the controller's view; the master modport is the environment's.
interface hilo_ctrl_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        mult_control;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport slave (
        input  start, op_a, op_b, mthi, mtlo, wdata, mult_hi, mult_lo,
        output mult_control, mult_a, mult_b, busy, done, hi_out, lo_out
    );

    modport master (
        output start, op_a, op_b, mthi, mtlo, wdata, mult_hi, mult_lo,
        input  mult_control, mult_a, mult_b, busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: launches a fixed-latency external multiplier,
// captures its product into HI/LO and services direct HI/LO writes while idle.
module hilo_ctrl #(
    parameter int MULT_LATENCY = 32
) (
    input logic        clk,
    input logic        reset,
    hilo_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    // The WAIT phase ends on the edge where the counter reads one.
    localparam logic [5:0] CNT_LOAD = 6'(MULT_LATENCY - 1);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        mc_q, mc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            mc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH:  state_d = WAIT;
            WAIT: begin
                if (cnt_q == 6'd1) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and HI/LO.
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        mc_d   = (state_d == LAUNCH);
        busy_d = (state_d != IDLE);
        done_d = (state_q == CAPTURE);
        case (state_q)
            IDLE: begin
                // A direct write and a launch may share an edge; the capture lands later.
                if (bus.mthi) begin
                    hi_d = bus.wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (bus.mtlo) begin
                    lo_d = bus.wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (bus.start) begin
                    a_d = bus.op_a;
                    b_d = bus.op_b;
                end else begin
                    a_d = a_q;
                    b_d = b_q;
                end
            end
            LAUNCH:  cnt_d = CNT_LOAD;
            WAIT:    cnt_d = cnt_q - 6'd1;
            CAPTURE: begin
                cnt_d = 6'd0;
                hi_d  = bus.mult_hi;
                lo_d  = bus.mult_lo;
            end
            default: cnt_d = 6'd0;
        endcase
    end

    assign bus.mult_control = mc_q;
    assign bus.mult_a       = a_q;
    assign bus.mult_b       = b_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: a fixed-latency multiplier stand-in, a transaction-level
// reference model checked every cycle, a product table and directed corner sequences.
module tb_hilo_ctrl;
    localparam int L = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_ctrl_if bus();
    hilo_ctrl #(.MULT_LATENCY(L)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 64'(sa * sb);
    endfunction

    // Multiplier stand-in: garbage until L edges after the launch is sampled.
    int m_cnt;
    always @(posedge clk) begin
        if (!reset) begin
            m_cnt       <= 0;
            bus.mult_hi <= 32'h0;
            bus.mult_lo <= 32'h0;
        end else if (bus.mult_control) begin
            m_cnt       <= 1;
            bus.mult_hi <= $urandom;
            bus.mult_lo <= $urandom;
        end else if (m_cnt == L - 1) begin
            {bus.mult_hi, bus.mult_lo} <= smul(bus.mult_a, bus.mult_b);
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Reference model: edges left until the operation ends, plus architectural values.
    int          busy_left;
    logic [63:0] pend;
    logic [31:0] e_a, e_b, e_hi, e_lo;
    logic        e_done, e_mc;

    task automatic model_zero();
        busy_left = 0;
        pend = 64'h0;
        e_a = 32'h0; e_b = 32'h0; e_hi = 32'h0; e_lo = 32'h0;
        e_done = 1'b0; e_mc = 1'b0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_zero();
        end else begin
            e_done = 1'b0;
            if (busy_left == 0) begin
                if (bus.mthi) e_hi = bus.wdata;
                if (bus.mtlo) e_lo = bus.wdata;
                if (bus.start) begin
                    e_a = bus.op_a;
                    e_b = bus.op_b;
                    pend = smul(bus.op_a, bus.op_b);
                    busy_left = L + 1;
                end
            end else begin
                busy_left--;
                if (busy_left == 0) begin
                    e_hi = pend[63:32];
                    e_lo = pend[31:0];
                    e_done = 1'b1;
                end
            end
            e_mc = (busy_left == L + 1);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy",         {31'd0, bus.busy},         {31'd0, busy_left > 0});
        chk("done",         {31'd0, bus.done},         {31'd0, e_done});
        chk("mult_control", {31'd0, bus.mult_control}, {31'd0, e_mc});
        chk("mult_a",       bus.mult_a,                e_a);
        chk("mult_b",       bus.mult_b,                e_b);
        chk("hi_out",       bus.hi_out,                e_hi);
        chk("lo_out",       bus.lo_out,                e_lo);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_in();
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.op_a = 32'h0; bus.op_b = 32'h0; bus.wdata = 32'h0;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
        tick();
        clear_in();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < L + 8) begin
            tick();
            n++;
            if (bus.done === 1'b1) break;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vt[8];

    initial begin
        int n;
        logic [31:0] lo_before;
        vt[0] = '{32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
        vt[1] = '{32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vt[3] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[4] = '{32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};
        vt[5] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vt[6] = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vt[7] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};

        reset = 1'b0;
        clear_in();
        model_zero();
        #1 check_all();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Product table: latency from the launch edge and pass-through of both words.
        for (int i = 0; i < 8; i++) begin
            launch(vt[i].a, vt[i].b);
            wait_done(n);
            chk("done_latency", 32'(n), 32'(L + 1));
            chk("tbl_hi", bus.hi_out, vt[i].hi);
            chk("tbl_lo", bus.lo_out, vt[i].lo);
        end
        tick();

        // Direct writes while idle.
        lo_before = e_lo;
        bus.mthi = 1'b1; bus.wdata = 32'h12345678;
        tick();
        clear_in();
        chk("mthi_hi", bus.hi_out, 32'h12345678);
        chk("mthi_lo_kept", bus.lo_out, lo_before);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5C3C3;
        tick();
        clear_in();
        chk("both_hi", bus.hi_out, 32'hA5A5C3C3);
        chk("both_lo", bus.lo_out, 32'hA5A5C3C3);

        // Writes and a second start during WAIT are ignored.
        launch(32'd3, 32'd4);
        repeat (5) tick();
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hDEADBEEF;
        bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
        tick();
        chk("wait_write_hi", bus.hi_out, 32'hA5A5C3C3);
        tick();
        clear_in();
        chk("wait_op_a_held", bus.mult_a, 32'd3);
        wait_done(n);
        chk("busy_ignore_latency", 32'(n), 32'(L + 1 - 7));
        chk("busy_ignore_lo", bus.lo_out, 32'd12);

        // Start accepted in the done cycle.
        launch(32'd100, 32'd200);
        wait_done(n);
        chk("done_cycle_latency", 32'(n + 1), 32'(L + 2));
        chk("done_cycle_lo", bus.lo_out, 32'd20000);
        tick();

        // Start together with mthi: write first, capture overwrites later.
        bus.start = 1'b1; bus.op_a = 32'd11; bus.op_b = 32'd13;
        bus.mthi = 1'b1; bus.wdata = 32'h0BADF00D;
        tick();
        clear_in();
        chk("start_mthi_hi", bus.hi_out, 32'h0BADF00D);
        wait_done(n);
        chk("start_mthi_cap_hi", bus.hi_out, 32'h0);
        chk("start_mthi_cap_lo", bus.lo_out, 32'd143);

        // Asynchronous reset in the middle of WAIT.
        launch(32'd7, 32'd6);
        repeat (10) tick();
        #3 reset = 1'b0;
        #1 model_zero();
        check_all();
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (L + 4) tick();
        launch(32'd2, 32'd3);
        wait_done(n);
        chk("restart_latency", 32'(n), 32'(L + 1));
        chk("restart_lo", bus.lo_out, 32'd6);

        // Random traffic against the reference model.
        for (int c = 0; c < 900; c++) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.mthi  = ($urandom_range(0, 5) == 0);
            bus.mtlo  = ($urandom_range(0, 5) == 0);
            bus.wdata = $urandom;
            bus.op_a  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            bus.op_b  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            tick();
        end
        clear_in();
        repeat (L + 4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
